// File: rtl/adc_scan_ctrl.sv
// Round-robin conversion sequencer for the ADC128S022 SPI driver, with a per-channel result file.
// Define ADC_AVG_EN to convert each channel 4 times and report the truncated mean of the four results.
module adc_scan_ctrl #(
    parameter int INTERVAL_W  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    input  logic [7:0]            ch_mask,
    input  logic [INTERVAL_W-1:0] interval,
    output logic                  adc_start,
    output logic [2:0]            adc_channel,
    input  logic                  adc_done,
    input  logic [11:0]           adc_data,
    input  logic [2:0]            rd_ch,
    output logic [11:0]           rd_data,
    output logic                  rd_valid,
    output logic                  smp_valid,
    output logic [2:0]            smp_ch,
    output logic [11:0]           smp_data,
    output logic                  scan_done,
    output logic                  timeout_err
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t                  state;
    logic [7:0]              mask_q;
    logic [2:0]              cur_ch;
    logic [WD_W-1:0]         wd_cnt;
    logic [INTERVAL_W-1:0]   gap_cnt;
    logic [11:0]             res_q [8];
    logic [7:0]              valid_q;

    logic [7:0]              rest_mask;
    logic                    wd_expired;
    logic                    last_conv;
    logic                    repeat_ch;
    logic [11:0]             result;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction

    // Channels still to visit in the current sweep: latched mask bits strictly above cur_ch.
    assign rest_mask  = mask_q & (8'hFE << cur_ch);
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

`ifdef ADC_AVG_EN
    logic [1:0]  avg_cnt;
    logic [13:0] acc;
    logic [13:0] acc_sum;

    assign acc_sum   = acc + {2'b00, adc_data};
    assign last_conv = (avg_cnt == 2'd3);
    assign repeat_ch = (avg_cnt != 2'd0);
    assign result    = acc_sum[13:2];
`else
    assign last_conv = 1'b1;
    assign repeat_ch = 1'b0;
    assign result    = adc_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask_q      <= '0;
            cur_ch      <= '0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            adc_start   <= 1'b0;
            adc_channel <= '0;
            smp_valid   <= 1'b0;
            smp_ch      <= '0;
            smp_data    <= '0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
            // NOTE: the result file is reset too, since rd_data must read 0 for never-written channels.
            res_q       <= '{default: '0};
            valid_q     <= '0;
`ifdef ADC_AVG_EN
            avg_cnt     <= '0;
            acc         <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low here so each branch only has to raise them for one cycle.
            adc_start <= 1'b0;
            smp_valid <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
`ifdef ADC_AVG_EN
                    avg_cnt <= '0;
                    acc     <= '0;
`endif
                    if (scan_en && ch_mask != 8'h00) begin
                        mask_q      <= ch_mask;
                        cur_ch      <= lowest(ch_mask);
                        adc_channel <= lowest(ch_mask);
                        adc_start   <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (adc_done) begin
                        gap_cnt <= interval;
                        state   <= GAP;
                        if (last_conv) begin
                            res_q[cur_ch]   <= result;
                            valid_q[cur_ch] <= 1'b1;
                            smp_valid       <= 1'b1;
                            smp_ch          <= cur_ch;
                            smp_data        <= result;
                        end
`ifdef ADC_AVG_EN
                        avg_cnt <= avg_cnt + 2'd1;
                        acc     <= last_conv ? '0 : acc_sum;
`endif
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= interval;
                        state       <= GAP;
`ifdef ADC_AVG_EN
                        avg_cnt <= '0;
                        acc     <= '0;
`endif
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (!scan_en) begin
                        state <= IDLE;
                    end else if (repeat_ch) begin
                        adc_start <= 1'b1;
                        state     <= START;
                    end else if (rest_mask != 8'h00) begin
                        cur_ch      <= lowest(rest_mask);
                        adc_channel <= lowest(rest_mask);
                        adc_start   <= 1'b1;
                        state       <= START;
                    end else begin
                        // Sweep boundary: the only point besides IDLE where a new mask is picked up.
                        scan_done <= 1'b1;
                        mask_q    <= ch_mask;
                        if (ch_mask != 8'h00) begin
                            cur_ch      <= lowest(ch_mask);
                            adc_channel <= lowest(ch_mask);
                            adc_start   <= 1'b1;
                            state       <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_data  = res_q[rd_ch];
    assign rd_valid = valid_q[rd_ch];

endmodule
